fifo_scoreboard: RTL and testbench
==================================

# fifo_scoreboard

Synthesizable, parametrised checker for a first-word-fall-through FIFO. It runs in parallel with the FIFO under test and holds a shadow queue of every accepted write. Each cycle it compares the FIFO's full, empty, almost-full, almost-empty and head-data outputs against that model. Mismatches are reported as sticky flags and saturating counters, so the same checker works in simulation benches and on-board self-test.

## Interface
Parameters:
- W, 8, data width
- S, 16, FIFO depth in entries; any value ≥ 2
- AF, 14, almost-full threshold (occupancy ≥ AF)
- AE, 2, almost-empty threshold (occupancy ≤ AE)
- CW, 16, width of the error counter and the cycle counter

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- iEN  in  1  checking enable; the model tracks traffic regardless
- iENQ  in  1  write strobe presented to the FIFO
- iDEQ  in  1  read strobe presented to the FIFO
- iD  in  W  write data
- iFULL, iEMPTY, iAFULL, iAEMPTY  in  1 each  status outputs of the FIFO under test
- iQ  in  W  head data of the FIFO under test
- oERR  out  1  sticky: any error since reset
- oERR_CODE  out  5  sticky per-class bits: [0] full, [1] empty, [2] data, [3] almost-full, [4] almost-empty
- oERR_CNT  out  CW  number of error cycles, saturating
- oFIRST_CYC  out  CW  cycle index of the first error
- oLEVEL  out  $clog2(S+1)  model occupancy

## Operation
- Model: RAM of S×W entries, write pointer, read pointer and level. Pointers wrap explicitly from S-1 to 0.
- Effective operations, decided from the pre-edge level:
  - write = iENQ && (level < S || iDEQ)
  - read = iDEQ && level > 0
  - Enqueue while empty with dequeue: only the write is performed.
  - Enqueue and dequeue while full: both are performed and the level is unchanged.
  - Enqueue while full without dequeue: dropped.
  - Dequeue while empty: ignored.
- Expected outputs, from the pre-edge model:
  - full = (level == S)
  - empty = (level == 0)
  - afull = (level ≥ AF)
  - aempty = (level ≤ AE)
  - head = mem[rd_ptr]
- Checks run only when iEN = 1 and reset = 0. The data check runs only when the expected empty is 0.
- An error cycle is any cycle in which at least one class mismatches. In that cycle:
  - the corresponding oERR_CODE bits are ORed in;
  - oERR is set;
  - oERR_CNT increments and holds at 2^CW−1;
  - oFIRST_CYC captures the cycle counter if oERR was 0.
- The cycle counter increments every non-reset cycle and saturates at 2^CW−1.

## Timing
- All state updates happen on the rising edge of clk.
- Checks compare the pre-edge FIFO outputs with the pre-edge model. Results appear on the outputs one cycle after the mismatching cycle.
- Reset takes priority over every other input, including mid-traffic. On reset:
  - level, pointers, cycle counter, oERR, oERR_CODE, oERR_CNT and oFIRST_CYC all go to 0.
  - RAM contents are not cleared.
- The first check happens in the first cycle with reset low. The FIFO under test is reset by the same reset, so it must show empty = 1, aempty = 1, full = 0 and afull = 0.
- iEN going low stops error accumulation only. Model tracking continues, so checking can resume mid-stream.
- oLEVEL is registered and reflects the post-edge model.

## Structure
- Package fifo_chk_pkg holds the oERR_CODE bit-index constants (ERR_FULL = 0 … ERR_AEMPTY = 4) and ERR_W = 5.
- Sub-module fifo_model holds the shadow RAM, pointers, level and expected-output generation. The top level holds the comparators, sticky flags and counters.

## Test plan
- After reset, enqueue 1..16 with S = 16, then dequeue 16 times against a correct FIFO. Required: oERR = 0, oLEVEL returns to 0, and iQ equals 1..16 in order.
- At level 16, drive iENQ alone with iD = 99. Required: oLEVEL stays 16 and no error; the next dequeued value is still 1.
- At level 16, drive iENQ and iDEQ together with iD = 77. Required: oLEVEL stays 16, and 77 is read out as the 16th element after the remaining 15.
- Force iQ = 0x55 while the model head is 3, at cycle 20 after reset. Required: one cycle later oERR_CODE = 5'b00100, oERR_CNT = 1, oFIRST_CYC = 20.
- Hold iAFULL = 0 at level 14 for 3 cycles with iEN = 1. Required: oERR_CODE[3] = 1 and oERR_CNT = 3. Repeat with iEN = 0: counts are unchanged.
- Assert reset in the middle of the data-error scenario. Required: all outputs return to 0 on the next edge, and a subsequent clean run keeps oERR = 0.

Source files
------------

// File: rtl/fifo_chk_pkg.sv
// Shared constants for the FIFO scoreboard.
// oERR_CODE bit positions, one per checked FIFO output class.
package fifo_chk_pkg;
  localparam int ERR_W      = 5;
  localparam int ERR_FULL   = 0;
  localparam int ERR_EMPTY  = 1;
  localparam int ERR_DATA   = 2;
  localparam int ERR_AFULL  = 3;
  localparam int ERR_AEMPTY = 4;
endpackage

// File: rtl/fifo_model.sv
// Shadow model of a first-word-fall-through FIFO.
// Tracks accepted writes and reads and produces the status and head data
// that a correct FIFO must show for the current (pre-edge) state.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   enq, deq, d           strobes and write data seen by the FIFO under test
//   level                 registered occupancy
//   exp_full/empty/afull/aempty, exp_head   expected FIFO outputs
module fifo_model
  import fifo_chk_pkg::*;
#(
  parameter int W  = 8,
  parameter int S  = 16,
  parameter int AF = 14,
  parameter int AE = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enq,
  input  logic                   deq,
  input  logic [W-1:0]           d,
  output logic [$clog2(S+1)-1:0] level,
  output logic                   exp_full,
  output logic                   exp_empty,
  output logic                   exp_afull,
  output logic                   exp_aempty,
  output logic [W-1:0]           exp_head
);

  localparam int LW = $clog2(S + 1);
  localparam int PW = (S > 1) ? $clog2(S) : 1;

  logic [W-1:0]  mem [S];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          wr;
  logic          rd;

  // A full FIFO still accepts a write when a read frees a slot in the same
  // cycle; an empty FIFO never reads, even if a write arrives alongside.
  always_comb begin
    wr = enq && ((level < LW'(S)) || deq);
    rd = deq && (level != '0);
  end

  always_comb begin
    exp_full   = (level == LW'(S));
    exp_empty  = (level == '0);
    exp_afull  = (level >= LW'(AF));
    exp_aempty = (level <= LW'(AE));
    exp_head   = mem[rd_ptr];
  end

  // RAM is not cleared on reset; reads are only meaningful when non-empty.
  always_ff @(posedge clk) begin
    if (!reset && wr) begin
      mem[wr_ptr] <= d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr) begin
        wr_ptr <= (wr_ptr == PW'(S - 1)) ? '0 : wr_ptr + PW'(1);
      end
      if (rd) begin
        rd_ptr <= (rd_ptr == PW'(S - 1)) ? '0 : rd_ptr + PW'(1);
      end
      case ({wr, rd})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/fifo_scoreboard.sv
// Parallel checker for a first-word-fall-through FIFO.
// Compares the FIFO's status and head data with a shadow model every cycle
// and records mismatches as sticky flags and saturating counters.
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   iEN                              checking enable (model always tracks)
//   iENQ, iDEQ, iD                   traffic presented to the FIFO
//   iFULL, iEMPTY, iAFULL, iAEMPTY, iQ   outputs of the FIFO under test
//   oERR                             sticky any-error flag
//   oERR_CODE                        sticky per-class error bits
//   oERR_CNT                         saturating count of error cycles
//   oFIRST_CYC                       cycle index of the first error
//   oLEVEL                           model occupancy (post-edge)
module fifo_scoreboard
  import fifo_chk_pkg::*;
#(
  parameter int W  = 8,
  parameter int S  = 16,
  parameter int AF = 14,
  parameter int AE = 2,
  parameter int CW = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   iEN,
  input  logic                   iENQ,
  input  logic                   iDEQ,
  input  logic [W-1:0]           iD,
  input  logic                   iFULL,
  input  logic                   iEMPTY,
  input  logic                   iAFULL,
  input  logic                   iAEMPTY,
  input  logic [W-1:0]           iQ,
  output logic                   oERR,
  output logic [ERR_W-1:0]       oERR_CODE,
  output logic [CW-1:0]          oERR_CNT,
  output logic [CW-1:0]          oFIRST_CYC,
  output logic [$clog2(S+1)-1:0] oLEVEL
);

  logic             exp_full;
  logic             exp_empty;
  logic             exp_afull;
  logic             exp_aempty;
  logic [W-1:0]     exp_head;
  logic [ERR_W-1:0] mism;
  logic [CW-1:0]    cyc;

  fifo_model #(
    .W  (W),
    .S  (S),
    .AF (AF),
    .AE (AE)
  ) u_model (
    .clk        (clk),
    .reset      (reset),
    .enq        (iENQ),
    .deq        (iDEQ),
    .d          (iD),
    .level      (oLEVEL),
    .exp_full   (exp_full),
    .exp_empty  (exp_empty),
    .exp_afull  (exp_afull),
    .exp_aempty (exp_aempty),
    .exp_head   (exp_head)
  );

  // Head data is only defined while the model holds at least one entry.
  always_comb begin
    mism = '0;
    if (iEN) begin
      mism[ERR_FULL]   = (iFULL   != exp_full);
      mism[ERR_EMPTY]  = (iEMPTY  != exp_empty);
      mism[ERR_DATA]   = !exp_empty && (iQ != exp_head);
      mism[ERR_AFULL]  = (iAFULL  != exp_afull);
      mism[ERR_AEMPTY] = (iAEMPTY != exp_aempty);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cyc        <= '0;
      oERR       <= 1'b0;
      oERR_CODE  <= '0;
      oERR_CNT   <= '0;
      oFIRST_CYC <= '0;
    end else begin
      if (cyc != '1) begin
        cyc <= cyc + CW'(1);
      end
      if (mism != '0) begin
        oERR      <= 1'b1;
        oERR_CODE <= oERR_CODE | mism;
        if (oERR_CNT != '1) begin
          oERR_CNT <= oERR_CNT + CW'(1);
        end
        if (!oERR) begin
          oFIRST_CYC <= cyc;
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_scoreboard.sv
module tb_fifo_scoreboard;

  localparam int W    = 8;
  localparam int S    = 16;
  localparam int AF   = 14;
  localparam int AE   = 2;
  localparam int CW   = 16;
  localparam int LW   = $clog2(S + 1);
  localparam int MAXV = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          iEN = 1'b1;
  logic          iENQ = 1'b0;
  logic          iDEQ = 1'b0;
  logic [W-1:0]  iD = '0;
  logic          iFULL = 1'b0;
  logic          iEMPTY = 1'b1;
  logic          iAFULL = 1'b0;
  logic          iAEMPTY = 1'b1;
  logic [W-1:0]  iQ = '0;
  logic          oERR;
  logic [4:0]    oERR_CODE;
  logic [CW-1:0] oERR_CNT;
  logic [CW-1:0] oFIRST_CYC;
  logic [LW-1:0] oLEVEL;

  fifo_scoreboard #(
    .W  (W),
    .S  (S),
    .AF (AF),
    .AE (AE),
    .CW (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .iEN        (iEN),
    .iENQ       (iENQ),
    .iDEQ       (iDEQ),
    .iD         (iD),
    .iFULL      (iFULL),
    .iEMPTY     (iEMPTY),
    .iAFULL     (iAFULL),
    .iAEMPTY    (iAEMPTY),
    .iQ         (iQ),
    .oERR       (oERR),
    .oERR_CODE  (oERR_CODE),
    .oERR_CNT   (oERR_CNT),
    .oFIRST_CYC (oFIRST_CYC),
    .oLEVEL     (oLEVEL)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference state: contents of a correct FIFO plus expected checker outputs.
  int unsigned q[$];
  int unsigned popped[$];
  int  m_err = 0;
  int  m_code = 0;
  int  m_cnt = 0;
  int  m_first = 0;
  int  m_cyc = 0;
  bit  started = 0;

  // Fault injection controls applied by drive_status.
  bit       force_q = 0;
  logic [W-1:0] force_val = '0;
  bit       force_af_low = 0;
  logic [4:0] flip = '0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    int n;
    int mm;
    bit do_rd;
    bit do_wr;
    if (reset) begin
      q.delete();
      m_err = 0; m_code = 0; m_cnt = 0; m_first = 0; m_cyc = 0;
    end else begin
      n = q.size();
      if (iEN) begin
        mm = 0;
        if (iFULL   != (n == S))  mm |= 1;
        if (iEMPTY  != (n == 0))  mm |= 2;
        if (n > 0 && int'(iQ) != q[0]) mm |= 4;
        if (iAFULL  != (n >= AF)) mm |= 8;
        if (iAEMPTY != (n <= AE)) mm |= 16;
        if (mm != 0) begin
          if (m_err == 0) m_first = m_cyc;
          m_err = 1;
          m_code |= mm;
          if (m_cnt < MAXV) m_cnt++;
        end
      end
      if (m_cyc < MAXV) m_cyc++;
      do_rd = iDEQ && n > 0;
      do_wr = iENQ && (n < S || iDEQ);
      if (do_rd) popped.push_back(q.pop_front());
      if (do_wr) q.push_back(int'(iD));
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("level",     oLEVEL,     q.size());
      chk("err",       oERR,       m_err);
      chk("err_code",  oERR_CODE,  m_code);
      chk("err_cnt",   oERR_CNT,   m_cnt);
      chk("first_cyc", oFIRST_CYC, m_first);
    end
  end

  // Present what a correct FIFO would show, with any requested faults.
  task automatic drive_status();
    int n;
    n = q.size();
    iFULL   = (n == S)  ^ flip[0];
    iEMPTY  = (n == 0)  ^ flip[1];
    iAFULL  = force_af_low ? 1'b0 : ((n >= AF) ^ flip[3]);
    iAEMPTY = (n <= AE) ^ flip[4];
    if (force_q)    iQ = force_val;
    else if (n > 0) iQ = W'(q[0]) ^ {{(W-1){1'b0}}, flip[2]};
    else            iQ = W'($urandom);
  endtask

  task automatic tick(input bit enq, input bit deq, input int unsigned d);
    iENQ = enq;
    iDEQ = deq;
    iD   = W'(d);
    drive_status();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(0, 0, 0);
    tick(0, 0, 0);
    reset = 1'b0;
  endtask

  initial begin
    #1;
    do_reset();
    started = 1;
    chk("reset_level", oLEVEL, 0);
    chk("reset_err",   oERR,   0);

    // Fill 1..16 then drain in order.
    for (int i = 1; i <= S; i++) tick(1, 0, i);
    chk("fill_level", oLEVEL, 16);
    popped.delete();
    for (int i = 0; i < S; i++) tick(0, 1, 0);
    chk("drain_level", oLEVEL, 0);
    chk("drain_err",   oERR,   0);
    for (int i = 0; i < S; i++) chk("drain_order", popped[i], i + 1);

    // Full: lone enqueue dropped, enqueue+dequeue replaces.
    for (int i = 1; i <= S; i++) tick(1, 0, i);
    tick(1, 0, 99);
    chk("full_drop_level", oLEVEL, 16);
    chk("full_drop_err",   oERR,   0);
    popped.delete();
    tick(1, 1, 77);
    chk("full_rw_level", oLEVEL, 16);
    chk("full_rw_pop",   popped[0], 1);
    popped.delete();
    for (int i = 0; i < S; i++) tick(0, 1, 0);
    chk("full_rw_first", popped[0], 2);
    chk("full_rw_last",  popped[15], 77);
    chk("full_rw_err",   oERR, 0);

    // Data error at cycle 20 with head 3.
    do_reset();
    for (int i = 1; i <= 10; i++) tick(1, 0, i);
    for (int i = 0; i < 8; i++) tick(0, 0, 0);
    tick(0, 1, 0);
    tick(0, 1, 0);
    force_q = 1; force_val = 8'h55;
    tick(0, 0, 0);
    chk("data_code",  oERR_CODE,  5'b00100);
    chk("data_cnt",   oERR_CNT,   1);
    chk("data_first", oFIRST_CYC, 20);
    tick(0, 0, 0);
    tick(0, 0, 0);
    reset = 1'b1;
    tick(0, 0, 0);
    force_q = 0;
    chk("midrst_err",   oERR,       0);
    chk("midrst_code",  oERR_CODE,  0);
    chk("midrst_cnt",   oERR_CNT,   0);
    chk("midrst_first", oFIRST_CYC, 0);
    chk("midrst_level", oLEVEL,     0);
    reset = 1'b0;
    for (int i = 0; i < 150; i++)
      tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 255));
    chk("clean_err", oERR, 0);

    // Almost-full stuck low at level 14, then with checking disabled.
    do_reset();
    for (int i = 1; i <= 14; i++) tick(1, 0, i);
    force_af_low = 1;
    for (int i = 0; i < 3; i++) tick(0, 0, 0);
    chk("af_bit", oERR_CODE[3], 1);
    chk("af_cnt", oERR_CNT, 3);
    iEN = 1'b0;
    for (int i = 0; i < 3; i++) tick(0, 0, 0);
    chk("af_dis_cnt", oERR_CNT, 3);
    force_af_low = 0;
    iEN = 1'b1;

    // Random traffic with sparse faults and enable toggling.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      flip = ($urandom_range(0, 19) == 0) ? 5'(1 << $urandom_range(0, 4)) : 5'b0;
      iEN  = ($urandom_range(0, 7) != 0);
      tick(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) == 0), $urandom_range(0, 255));
    end
    for (int i = 0; i < 300; i++) begin
      flip = ($urandom_range(0, 19) == 0) ? 5'(1 << $urandom_range(0, 4)) : 5'b0;
      tick(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) != 0), $urandom_range(0, 255));
    end
    flip = '0;
    tick(0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
